// File: rtl/reg_bank_cmd_ctrl.sv
// Command front-end for the 14 x 16-bit register bank: FIFO-buffered commands, serialised bank strobes, in-order responses.
// Optional macro REG_BANK_ADDR_CHECK_EN: flag and suppress commands whose address is >= NUM_REGS.
module reg_bank_cmd_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 14,
   parameter int DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [ADDR_W-1:0]            cmd_addr,
   input  logic [DATA_W-1:0]            cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_write,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         bank_write_en,
   output logic                         bank_read_en,
   output logic [ADDR_W-1:0]            bank_addr,
   output logic [DATA_W-1:0]            bank_data_in,
   input  logic [DATA_W-1:0]            bank_data_out,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RSP} state_t;

   state_t              state;
   logic                fifo_write [DEPTH];
   logic [ADDR_W-1:0]   fifo_addr  [DEPTH];
   logic [DATA_W-1:0]   fifo_data  [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    count;
   logic                push;
   logic                pop;
   logic                head_write;
   logic [ADDR_W-1:0]   head_addr;
   logic [DATA_W-1:0]   head_data;

   // cmd_ready comes from the registered level only, never from cmd_valid.
   assign cmd_ready  = (count != LVL_W'(DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && (count != '0);
   assign head_write = fifo_write[rd_ptr];
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];
   assign busy       = (state != IDLE) || (count != '0);
   assign fifo_level = count;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= cmd_write;
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_data[wr_ptr]  <= cmd_wdata;
      end
   end

`ifdef REG_BANK_ADDR_CHECK_EN
   localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
   logic err_q;
   logic head_bad;
   assign head_bad = ({1'b0, head_addr} >= NUM_REGS_C);
   assign rsp_err  = err_q;
`else
   assign rsp_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         state         <= IDLE;
         bank_write_en <= 1'b0;
         bank_read_en  <= 1'b0;
         bank_addr     <= '0;
         bank_data_in  <= '0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
`ifdef REG_BANK_ADDR_CHECK_EN
         err_q         <= 1'b0;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase

         bank_write_en <= 1'b0;
         bank_read_en  <= 1'b0;

         case (state)
            IDLE: begin
               if (pop) begin
`ifdef REG_BANK_ADDR_CHECK_EN
                  if (head_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_write <= head_write;
                     rsp_rdata <= '0;
                     err_q     <= 1'b1;
                     state     <= RSP;
                  end else
`endif
                  begin
                     bank_addr     <= head_addr;
                     bank_data_in  <= head_data;
                     bank_write_en <= head_write;
                     bank_read_en  <= !head_write;
                     state         <= ISSUE;
                  end
               end
            end
            // The strobe registered in IDLE is high for this one cycle and tells us the op.
            ISSUE: begin
               if (bank_write_en) begin
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b1;
                  rsp_rdata <= '0;
`ifdef REG_BANK_ADDR_CHECK_EN
                  err_q     <= 1'b0;
`endif
                  state     <= RSP;
               end else begin
                  state     <= CAPT;
               end
            end
            CAPT: begin
               rsp_valid <= 1'b1;
               rsp_write <= 1'b0;
               rsp_rdata <= bank_data_out;
`ifdef REG_BANK_ADDR_CHECK_EN
               err_q     <= 1'b0;
`endif
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/reg_bank_cmd_ctrl.md
Name: reg_bank_cmd_ctrl

Overview:
Command front-end that sits directly upstream of the 14 x 16-bit register bank (`top`). It accepts read/write commands on a valid/ready interface and buffers them in a small FIFO. It serialises the commands onto the bank's write_en/read_en/addr/data_in strobes, captures the bank's registered data_out, and returns one response per command on a valid/ready response channel. It optionally flags and suppresses out-of-range addresses.

Parameters:
- DATA_W, 16, bank data width
- ADDR_W, 4, bank address width
- NUM_REGS, 14, number of implemented bank registers; valid addresses are 0..NUM_REGS-1
- DEPTH, 4, command FIFO entries; power of 2, minimum 2

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  address out of range (see Optional Feature)
- bank_write_en  out  1  to bank write_en
- bank_read_en  out  1  to bank read_en
- bank_addr  out  ADDR_W  to bank addr
- bank_data_in  out  DATA_W  to bank data_in
- bank_data_out  in  DATA_W  from bank data_out; registered, valid the cycle after read_en is sampled
- busy  out  1  FSM not IDLE or FIFO not empty
- fifo_level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst == 0 at a rising edge):
  - FIFO flushed; fifo_level = 0; cmd_ready = 1 from the next cycle.
  - FSM goes to IDLE.
  - All bank_* outputs, rsp_* outputs and busy = 0.
  - Reset mid-operation abandons any in-flight command and drops any pending response. No strobe is asserted in the cycle after the reset edge.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, derived from registered state only, so it never combinationally depends on cmd_valid.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - When full, a push is impossible and only the pop occurs.
- FSM, with all bank_* outputs registered:
  - IDLE: if FIFO not empty, pop the head, load bank_addr/bank_data_in, assert the strobe for the op, go to ISSUE.
  - ISSUE: strobe is high for exactly this one cycle.
    - Write: go to RSP with rsp_write = 1 and rsp_rdata = 0.
    - Read: go to CAPT.
  - CAPT: strobes low. At the end of the cycle, register rsp_rdata <= bank_data_out and go to RSP.
  - RSP: rsp_valid = 1. All rsp_* fields are held stable until rsp_ready is seen. On the handshake, go to IDLE.
- Latency (cmd accepted at edge E0, FSM idle, FIFO empty):
  - Strobe high in cycle E1..E2.
  - Write: rsp_valid from E2.
  - Read: rsp_valid from E3.
  - Back-to-back throughput: 1 write per 3 cycles, 1 read per 4 cycles, when rsp_ready is held at 1.
- Ordering: responses are returned strictly in command order; exactly one response per accepted command.
- bank_write_en and bank_read_en are never high together.
- bank_addr and bank_data_in hold their last value when strobes are low.

Optional Feature:
- Macro: REG_BANK_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a popped command with addr >= NUM_REGS asserts no strobe.
  - The FSM goes straight to RSP with rsp_err = 1 and rsp_rdata = 0, one cycle after the pop.
  - busy still covers this path.
- Undefined:
  - Every command is forwarded to the bank unchanged; rsp_err is tied to 0.
  - Out-of-range behaviour is whatever the bank does: writes are ignored and reads return 0.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with cmd_valid = 1 → no push; fifo_level = 0, all strobes 0, rsp_valid = 0; after release, cmd_ready = 1.
- Write then read: write addr 3 data 0x1234, then read addr 3, with rsp_ready = 1 → bank_write_en for 1 cycle with addr 3 / 0x1234; write rsp at E2 with rsp_write = 1; read rsp rsp_rdata = 0x1234 with rsp_write = 0, arriving 4 cycles after the write response.
- Backpressure: hold rsp_ready = 0 and push 6 commands (DEPTH = 4) → cmd_ready drops after 5 accepted (4 in FIFO + 1 in flight); the response stays stable; releasing rsp_ready drains all 5 in order.
- Extremes: write 0x0000 to reg 0, 0xFFFF to reg 1, 0xAAAA to reg 2, then read each → exact values returned in order.
- Out-of-range: write 0xBEEF to addr 15, then read addr 15.
  - With REG_BANK_ADDR_CHECK_EN: no strobes, rsp_err = 1 twice, rsp_rdata = 0.
  - Without: strobes issued, rsp_err = 0, read data 0x0000.
- Reset mid-read: deassert rst during CAPT → no response emitted; the next command after reset completes normally with correct data.
